conv_window_mac: RTL
====================

CONV_WINDOW_MAC -- requirements
Module: conv_window_mac

Interface
REQ-001 Parameter X, default 4, SHALL set the pixel and coefficient width in bits.
REQ-002 Parameter N, default 9, SHALL set the taps per window (3x3 filter); legal range is 2..16.
REQ-003 Parameter AW, default 2*X+4, SHALL set the accumulator width, sized to cover N products without overflow.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 Start  input  1  SHALL be a pulse that begins one window; it is sampled only in IDLE.
REQ-007 in_valid  input  1  SHALL indicate that pix_in/coef_in hold a valid tap pair.
REQ-008 in_ready  output  1  SHALL indicate that the block accepts a tap pair this cycle.
REQ-009 pix_in  input  X  SHALL carry the unsigned image pixel.
REQ-010 coef_in  input  X  SHALL carry the signed two's-complement filter coefficient.
REQ-011 mul_start  output  1  SHALL be the Start drive to the combinational multiplier.
REQ-012 mul_a  output  X  SHALL be the unsigned multiplier operand and SHALL equal pix_in.
REQ-013 mul_b  output  X  SHALL be the signed multiplier operand and SHALL equal coef_in.
REQ-014 mul_p  input  2X  SHALL be the signed product, which arrives in the same cycle; it SHALL be 0 when mul_start=0.
REQ-015 acc_out  output  AW  SHALL be the signed window sum, valid while out_valid=1.
REQ-016 out_valid  output  1  SHALL indicate that acc_out holds a completed result.
REQ-017 out_ready  input  1  SHALL indicate that the downstream block consumes the result.
REQ-018 busy  output  1  SHALL be 1 in every state other than IDLE.

Function
REQ-019 The block SHALL implement states IDLE, ACC and HOLD.
REQ-020 IDLE -> ACC SHALL occur on Start=1; the accumulator and tap counter SHALL clear on that edge.
REQ-021 In ACC, in_ready SHALL be 1, and mul_start SHALL be in_valid & in_ready (combinational).
REQ-022 A transfer SHALL occur when in_valid & in_ready; on that edge, acc += sign-extended mul_p and the counter increments.
REQ-023 in_valid=0 in ACC SHALL be a stall: accumulator and counter hold, and the block stays in ACC indefinitely.
REQ-024 The N-th transfer SHALL move ACC -> HOLD and register acc_out = the full N-term sum, with out_valid=1 on the next cycle.
REQ-025 Latency from the last tap transfer to out_valid SHALL be exactly 1 cycle.
REQ-026 In HOLD, in_ready and mul_start SHALL be 0, and acc_out SHALL stay stable until out_ready=1.
REQ-027 HOLD -> IDLE SHALL occur on out_ready=1; out_valid SHALL drop on that same edge.
REQ-028 Start in ACC or HOLD SHALL be ignored and SHALL NOT be queued.
REQ-029 Start and out_ready arriving together in HOLD SHALL complete the handshake only; a new window needs a fresh Start in IDLE.
REQ-030 The counter SHALL span 0..N-1 with no wrap past N; in_valid outside ACC SHALL be ignored.
REQ-031 Arithmetic SHALL be signed throughout; the worst case (X=4, N=9) spans -1080..945, which fits in AW=12.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, acc=0, count=0, acc_out=0, out_valid=0, in_ready=0, mul_start=0 and busy=0.
REQ-033 Reset mid-ACC or mid-HOLD SHALL discard the partial or held result; after release, no out_valid SHALL appear without a new Start.

Configuration
REQ-034 Macro CONV_MAC_RELU_EN, when defined, SHALL register acc_out as max(sum, 0); when undefined, acc_out SHALL be the raw signed sum.

Verification
REQ-035 Start; 9 taps pix=15, coef=-8, back-to-back; out_ready=1 -> out_valid one cycle after the 9th tap with acc_out=-1080 (0 if CONV_MAC_RELU_EN).
REQ-036 Taps pix=15, coef=7 ×9 with in_valid low on alternate cycles -> acc_out=945, and no accumulation on idle cycles.
REQ-037 Taps pix=1..9 with coef=+1,-1 alternating; out_ready low for 5 cycles -> acc_out=5, stable across the stall; IDLE after out_ready.
REQ-038 Start pulses during ACC and HOLD -> no restart; exactly one result of the first window.
REQ-039 rst_n low after 4 taps, then Start and 9 taps pix=2, coef=3 -> acc_out=54 with no stale contribution.
REQ-040 mul_start checked every cycle -> asserted only on accepted transfers; mul_a and mul_b equal pix_in and coef_in.

Source files
------------

// File: rtl/conv_window_mac.sv
// Sequential 3x3-style window MAC: accumulates N pixel*coefficient products from an
// external combinational multiplier. Define CONV_MAC_RELU_EN to clamp the registered result at zero.
module conv_window_mac #(
    parameter int X  = 4,
    parameter int N  = 9,
    parameter int AW = 2*X+4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [X-1:0]         pix_in,
    input  logic signed [X-1:0]  coef_in,
    output logic                 mul_start,
    output logic [X-1:0]         mul_a,
    output logic signed [X-1:0]  mul_b,
    input  logic signed [2*X-1:0] mul_p,
    output logic signed [AW-1:0] acc_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic signed [AW-1:0]  acc_out_q, acc_out_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;

    logic                  xfer;
    logic                  last_tap;
    logic signed [AW-1:0]  prod_ext;
    logic signed [AW-1:0]  sum;

    function automatic logic signed [AW-1:0] relu(input logic signed [AW-1:0] v);
`ifdef CONV_MAC_RELU_EN
        return v[AW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // The multiplier sees the raw tap pair; mul_start gates whether its product is meaningful.
    assign mul_a     = pix_in;
    assign mul_b     = coef_in;
    assign in_ready  = (state_q == ACC);
    assign xfer      = in_valid & in_ready;
    assign mul_start = xfer;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign acc_out   = acc_out_q;

    assign prod_ext = {{(AW-2*X){mul_p[2*X-1]}}, mul_p};
    assign sum      = acc_q + prod_ext;
    assign last_tap = (cnt_q == CW'(N-1));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        acc_out_d   = acc_out_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            ACC: begin
                if (xfer) begin
                    acc_d = sum;
                    if (last_tap) begin
                        state_d     = HOLD;
                        acc_out_d   = relu(sum);
                        out_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                // Start is deliberately not looked at here, so it cannot queue a new window.
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            acc_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            acc_out_q   <= acc_out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
